// File: rtl/eth_header_checker.sv
// eth_header_checker
// Receive-path Ethernet header checker. Consumes one byte per cycle while
// control is high and walks preamble/SFD, destination address, source
// address and type/length, pulsing one flag per validated field. After the
// header it counts payload bytes and, at end of frame (control sampled low),
// pulses packet_size_valid when the length is in bounds and bumps a
// saturating count of valid packets.
//
// Ports:
//   clock                 in   1      rising-edge clock
//   reset                 in   1      asynchronous active-high reset
//   data                  in   8      received byte (used only when control=1)
//   control               in   1      byte valid / frame active
//   promisc               in   1      1 = accept any destination address
//   preamble_valid        out  1      pulse when SFD accepted
//   dst_addr_valid        out  1      pulse when 6th DST byte accepted
//   src_addr_valid        out  1      pulse when 6th SRC byte accepted
//   type_length_valid     out  1      pulse when 2nd T/L byte accepted
//   packet_size_valid     out  1      pulse at end of frame, payload in bounds
//   valid_packet_counter  out  CNT_W  saturating count of valid packets
module eth_header_checker #(
  parameter int          PREAMBLE_LEN = 7,
  parameter logic [47:0] DST_ADDR     = 48'h010203040506,
  parameter logic [47:0] SRC_ADDR     = 48'hFFFEFDFCFBFA,
  parameter logic [15:0] TYPE_LEN     = 16'h0800,
  parameter int          MIN_PAYLOAD  = 46,
  parameter int          MAX_PAYLOAD  = 1500,
  parameter int          CNT_W        = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       data,
  input  logic             control,
  input  logic             promisc,
  output logic             preamble_valid,
  output logic             dst_addr_valid,
  output logic             src_addr_valid,
  output logic             type_length_valid,
  output logic             packet_size_valid,
  output logic [CNT_W-1:0] valid_packet_counter
);

  // Payload count must be able to hold MAX_PAYLOAD+1.
  localparam int PAY_W = $clog2(MAX_PAYLOAD + 2);
  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);

  localparam logic [PAY_W-1:0] MIN_P    = PAY_W'(MIN_PAYLOAD);
  localparam logic [PAY_W-1:0] MAX_P    = PAY_W'(MAX_PAYLOAD);
  localparam logic [PAY_W-1:0] PAY_ZERO = {PAY_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_LEN  = PRE_W'(PREAMBLE_LEN);
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    SFD     = 3'd2,
    DST     = 3'd3,
    SRC     = 3'd4,
    TL      = 3'd5,
    PAYLOAD = 3'd6,
    DROP    = 3'd7
  } state_t;

  state_t           state_r, state_s;
  logic [PRE_W-1:0] pre_cnt_r, pre_cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic [PAY_W-1:0] pay_cnt_r, pay_cnt_s;
  logic             pre_v_s, dst_v_s, src_v_s, tl_v_s, pkt_v_s;
  logic             resync_s;

  // Address byte selected by index; index 0 is the first byte on the wire.
  function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
    case (idx)
      3'd0:    addr_byte = addr[47:40];
      3'd1:    addr_byte = addr[39:32];
      3'd2:    addr_byte = addr[31:24];
      3'd3:    addr_byte = addr[23:16];
      3'd4:    addr_byte = addr[15:8];
      3'd5:    addr_byte = addr[7:0];
      default: addr_byte = 8'h00;
    endcase
  endfunction

  // Next-state and flag decode.
  always_comb begin
    state_s   = state_r;
    pre_cnt_s = pre_cnt_r;
    idx_s     = idx_r;
    pay_cnt_s = pay_cnt_r;
    pre_v_s   = 1'b0;
    dst_v_s   = 1'b0;
    src_v_s   = 1'b0;
    tl_v_s    = 1'b0;
    pkt_v_s   = 1'b0;
    // A header mismatch on a 0x55 byte is treated as the first preamble byte.
    resync_s  = (data == 8'h55);

    if (!control) begin
      // End of frame or idle gap: every state returns to IDLE.
      state_s   = IDLE;
      pre_cnt_s = PRE_ZERO;
      idx_s     = 3'd0;
      pay_cnt_s = PAY_ZERO;
      if ((state_r == PAYLOAD) && (pay_cnt_r >= MIN_P) && (pay_cnt_r <= MAX_P)) begin
        pkt_v_s = 1'b1;
      end else begin
        pkt_v_s = 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (data == 8'h55) begin
            state_s   = PRE;
            pre_cnt_s = PRE_ONE;
          end else begin
            state_s = IDLE;
          end
        end
        PRE: begin
          if (data == 8'h55) begin
            pre_cnt_s = pre_cnt_r + PRE_ONE;
            state_s   = ((pre_cnt_r + PRE_ONE) >= PRE_LEN) ? SFD : PRE;
          end else begin
            state_s   = IDLE;
            pre_cnt_s = PRE_ZERO;
          end
        end
        SFD: begin
          if (data == 8'hD5) begin
            state_s   = DST;
            idx_s     = 3'd0;
            pre_cnt_s = PRE_ZERO;
            pre_v_s   = 1'b1;
          end else if (data == 8'h55) begin
            state_s = SFD;
          end else begin
            state_s   = IDLE;
            pre_cnt_s = PRE_ZERO;
          end
        end
        DST: begin
          if (promisc || (data == addr_byte(DST_ADDR, idx_r))) begin
            if (idx_r == 3'd5) begin
              state_s = SRC;
              idx_s   = 3'd0;
              dst_v_s = 1'b1;
            end else begin
              idx_s = idx_r + 3'd1;
            end
          end else begin
            state_s   = resync_s ? PRE : IDLE;
            pre_cnt_s = resync_s ? PRE_ONE : PRE_ZERO;
            idx_s     = 3'd0;
          end
        end
        SRC: begin
          if (data == addr_byte(SRC_ADDR, idx_r)) begin
            if (idx_r == 3'd5) begin
              state_s = TL;
              idx_s   = 3'd0;
              src_v_s = 1'b1;
            end else begin
              idx_s = idx_r + 3'd1;
            end
          end else begin
            state_s   = resync_s ? PRE : IDLE;
            pre_cnt_s = resync_s ? PRE_ONE : PRE_ZERO;
            idx_s     = 3'd0;
          end
        end
        TL: begin
          if (data == (idx_r[0] ? TYPE_LEN[7:0] : TYPE_LEN[15:8])) begin
            if (idx_r[0]) begin
              state_s   = PAYLOAD;
              idx_s     = 3'd0;
              pay_cnt_s = PAY_ZERO;
              tl_v_s    = 1'b1;
            end else begin
              idx_s = idx_r + 3'd1;
            end
          end else begin
            state_s   = resync_s ? PRE : IDLE;
            pre_cnt_s = resync_s ? PRE_ONE : PRE_ZERO;
            idx_s     = 3'd0;
          end
        end
        PAYLOAD: begin
          // One more byte beyond MAX_PAYLOAD makes the frame oversize.
          if (pay_cnt_r == MAX_P) begin
            state_s = DROP;
          end else begin
            pay_cnt_s = pay_cnt_r + {{(PAY_W-1){1'b0}}, 1'b1};
          end
        end
        DROP: begin
          state_s = DROP;
        end
        default: begin
          state_s   = IDLE;
          pre_cnt_s = PRE_ZERO;
          idx_s     = 3'd0;
          pay_cnt_s = PAY_ZERO;
        end
      endcase
    end
  end

  // State, counts and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r              <= IDLE;
      pre_cnt_r            <= PRE_ZERO;
      idx_r                <= 3'd0;
      pay_cnt_r            <= PAY_ZERO;
      preamble_valid       <= 1'b0;
      dst_addr_valid       <= 1'b0;
      src_addr_valid       <= 1'b0;
      type_length_valid    <= 1'b0;
      packet_size_valid    <= 1'b0;
      valid_packet_counter <= {CNT_W{1'b0}};
    end else begin
      state_r           <= state_s;
      pre_cnt_r         <= pre_cnt_s;
      idx_r             <= idx_s;
      pay_cnt_r         <= pay_cnt_s;
      preamble_valid    <= pre_v_s;
      dst_addr_valid    <= dst_v_s;
      src_addr_valid    <= src_v_s;
      type_length_valid <= tl_v_s;
      packet_size_valid <= pkt_v_s;
      if (pkt_v_s && (valid_packet_counter != CNT_MAX)) begin
        valid_packet_counter <= valid_packet_counter + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        valid_packet_counter <= valid_packet_counter;
      end
    end
  end

endmodule

// File: tb/tb_eth_header_checker.sv
// tb_eth_header_checker
// Directed bench for eth_header_checker with default parameters. Bytes and
// the flag vector expected after each byte are queued, then played one per
// clock; flags and counter are sampled 1 time unit after the rising edge.
module tb_eth_header_checker;

  logic       clock;
  logic       reset;
  logic [7:0] data;
  logic       control;
  logic       promisc;
  logic       preamble_valid;
  logic       dst_addr_valid;
  logic       src_addr_valid;
  logic       type_length_valid;
  logic       packet_size_valid;
  logic [3:0] valid_packet_counter;
  logic [4:0] flags;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] bq[$];
  logic [4:0] fq[$];

  eth_header_checker dut (
    .clock               (clock),
    .reset               (reset),
    .data                (data),
    .control             (control),
    .promisc             (promisc),
    .preamble_valid      (preamble_valid),
    .dst_addr_valid      (dst_addr_valid),
    .src_addr_valid      (src_addr_valid),
    .type_length_valid   (type_length_valid),
    .packet_size_valid   (packet_size_valid),
    .valid_packet_counter(valid_packet_counter)
  );

  // {preamble, dst, src, type/length, packet size}
  assign flags = {preamble_valid, dst_addr_valid, src_addr_valid,
                  type_length_valid, packet_size_valid};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic [4:0] f);
    bq.push_back(b);
    fq.push_back(f);
  endtask

  task automatic push_pre();
    repeat (7) push(8'h55, 5'b00000);
    push(8'hD5, 5'b10000);
  endtask

  // bad >= 0 replaces that DST byte with 0x13; ok says whether 6th byte pulses.
  task automatic push_dst(input int bad, input bit ok);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = 8'h01 + 8'(i);
      if (i == bad) b = 8'h13;
      push(b, (i == 5 && ok) ? 5'b01000 : 5'b00000);
    end
  endtask

  task automatic push_src(input bit ok);
    for (int i = 0; i < 6; i++) push(8'hFF - 8'(i), (i == 5 && ok) ? 5'b00100 : 5'b00000);
  endtask

  task automatic push_tl(input bit ok);
    push(8'h08, 5'b00000);
    push(8'h00, ok ? 5'b00010 : 5'b00000);
  endtask

  // Payload bytes never equal 0x55.
  task automatic push_payload(input int n);
    for (int i = 0; i < n; i++) push(8'(i % 64), 5'b00000);
  endtask

  task automatic push_good_header();
    push_pre();
    push_dst(-1, 1'b1);
    push_src(1'b1);
    push_tl(1'b1);
  endtask

  task automatic play(input string tag);
    for (int i = 0; i < bq.size(); i++) begin
      data    = bq[i];
      control = 1'b1;
      @(posedge clock);
      #1;
      check(tag, 32'(flags), 32'(fq[i]));
    end
    bq.delete();
    fq.delete();
  endtask

  // control low for two cycles with 0x55 on data (must be ignored).
  task automatic end_frame(input string tag, input bit psv, input logic [3:0] cnt);
    control = 1'b0;
    data    = 8'h55;
    @(posedge clock);
    #1;
    check({tag, "_eof_flags"}, 32'(flags), 32'({4'b0000, psv}));
    check({tag, "_counter"}, 32'(valid_packet_counter), 32'(cnt));
    @(posedge clock);
    #1;
    check({tag, "_gap_flags"}, 32'(flags), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    control = 1'b0;
    data    = 8'h00;
    promisc = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_counter", 32'(valid_packet_counter), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Nominal frame, 46 payload bytes
    push_good_header();
    push_payload(46);
    play("nominal");
    end_frame("nominal", 1'b1, 4'd1);

    // Bad 3rd DST byte: parser drops to IDLE, rest of frame ignored
    push_pre();
    push_dst(2, 1'b0);
    push_src(1'b0);
    push_tl(1'b0);
    push_payload(46);
    play("bad_dst");
    end_frame("bad_dst", 1'b0, 4'd1);

    push_good_header();
    push_payload(50);
    play("after_bad_dst");
    end_frame("after_bad_dst", 1'b1, 4'd2);

    // Same bad DST byte accepted in promiscuous mode
    promisc = 1'b1;
    push_pre();
    push_dst(2, 1'b1);
    push_src(1'b1);
    push_tl(1'b1);
    push_payload(46);
    play("promisc");
    end_frame("promisc", 1'b1, 4'd3);
    promisc = 1'b0;

    // Resync: 0x55 as 2nd SRC byte, then 6 more 0x55 and SFD
    push_pre();
    push_dst(-1, 1'b1);
    push(8'hFF, 5'b00000);
    repeat (7) push(8'h55, 5'b00000);
    push(8'hD5, 5'b10000);
    push_dst(-1, 1'b1);
    push_src(1'b1);
    push_tl(1'b1);
    push_payload(46);
    play("resync");
    end_frame("resync", 1'b1, 4'd4);

    // Payload bounds
    push_good_header();
    push_payload(45);
    play("pay45");
    end_frame("pay45", 1'b0, 4'd4);

    push_good_header();
    push_payload(1500);
    play("pay1500");
    end_frame("pay1500", 1'b1, 4'd5);

    push_good_header();
    push_payload(1501);
    play("pay1501");
    end_frame("pay1501", 1'b0, 4'd5);

    // Asynchronous reset while in SRC, coinciding with the dst pulse
    push_pre();
    push_dst(-1, 1'b1);
    play("pre_reset");
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_flags", 32'(flags), 32'd0);
    check("async_reset_counter", 32'(valid_packet_counter), 32'd0);
    control = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Fresh frame after reset, then saturation over 17 frames total
    push_good_header();
    push_payload(46);
    play("post_reset");
    end_frame("post_reset", 1'b1, 4'd1);

    for (int k = 2; k <= 17; k++) begin
      push_good_header();
      push_payload(46);
      play("sat");
      end_frame("sat", 1'b1, (k > 15) ? 4'd15 : 4'(k));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/eth_header_checker.md
# eth_header_checker

Parametrised Ethernet frame-header checker for the receive byte path, successor to the fixed-pattern header FSM. It consumes one byte per cycle while `control` is high, then checks the preamble/SFD, destination address, source address and type/length. After the header it counts payload bytes and checks that the payload length is within bounds. It pulses one flag per validated field and keeps a saturating count of fully valid packets for the status block.

## Interface
- `PREAMBLE_LEN`, 7: minimum number of 0x55 bytes before SFD 0xD5.
- `DST_ADDR`, 48'h010203040506: expected destination address; [47:40] is received first.
- `SRC_ADDR`, 48'hFFFEFDFCFBFA: expected source address; [47:40] is received first.
- `TYPE_LEN`, 16'h0800: expected type/length; [15:8] is received first.
- `MIN_PAYLOAD`, 46: minimum payload bytes.
- `MAX_PAYLOAD`, 1500: maximum payload bytes.
- `CNT_W`, 4: width of the valid-packet counter.

Ports:
- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state and outputs.
- `data`  in  8: received byte; sampled only when `control`=1.
- `control`  in  1: byte-valid/frame-active. A falling edge, meaning `control` is sampled 0 after a 1, marks end of frame.
- `promisc`  in  1: 1 = skip the destination-address comparison. `dst_addr_valid` still pulses.
- `preamble_valid`  out  1: one-cycle pulse when the SFD is accepted.
- `dst_addr_valid`  out  1: one-cycle pulse when the 6th DST byte is accepted.
- `src_addr_valid`  out  1: one-cycle pulse when the 6th SRC byte is accepted.
- `type_length_valid`  out  1: one-cycle pulse when the 2nd T/L byte is accepted.
- `packet_size_valid`  out  1: one-cycle pulse at end of frame when the payload length is in bounds.
- `valid_packet_counter`  out  CNT_W: number of fully valid packets; saturates at all-ones.

## Operation
- States:
  - IDLE
  - PRE: counting 0x55 bytes
  - SFD: at least PREAMBLE_LEN bytes of 0x55 seen
  - DST: byte index 0-5
  - SRC: byte index 0-5
  - TL: byte index 0-1
  - PAYLOAD
  - DROP: wait for `control` low
- IDLE:
  - 0x55 with `control`=1 → PRE, preamble count = 1.
  - Any other byte → stay in IDLE.
- PRE:
  - 0x55 → increment count; when count reaches PREAMBLE_LEN → SFD.
  - Any other byte → mismatch.
- SFD:
  - 0xD5 → DST, index 0, pulse `preamble_valid`.
  - 0x55 → stay in SFD (long preamble is tolerated).
  - Other byte → mismatch.
- DST, SRC, TL: compare each byte with the parameter slice selected by the index.
  - Match on the last byte → pulse the field flag and advance to the next state.
  - Any other byte mismatch → mismatch.
  - In DST, `promisc`=1 forces a match.
- Mismatch (any header state):
  - Byte is 0x55 → go to PRE with count 1 (resync).
  - Otherwise → IDLE.
  - No flag pulses.
- PAYLOAD:
  - Each `control`=1 cycle increments the payload count. The count is wide enough for MAX_PAYLOAD+1.
  - Count would exceed MAX_PAYLOAD → DROP.
- `control`=0 behaviour:
  - Sampled 0 in PAYLOAD: if MIN_PAYLOAD ≤ count ≤ MAX_PAYLOAD, pulse `packet_size_valid` and increment the counter (unless already all-ones); otherwise no pulse. Then → IDLE.
  - Sampled 0 in any header state: abort → IDLE, no pulse.
  - Sampled 0 in DROP: → IDLE, no pulse.
- The header flags of one frame may all pulse even if `packet_size_valid` later fails. Only a `packet_size_valid` pulse counts as a valid packet.

## Timing
- Reset values: all flags 0, `valid_packet_counter` 0, state IDLE, internal counts 0. Reset takes effect immediately, including mid-frame; the first byte after release is treated as in IDLE.
- All outputs are registered. Each flag is high for exactly one cycle: the cycle after the edge that samples the qualifying byte.
- `packet_size_valid` and the counter increment appear together, on the cycle after the first `control`=0 sample.
- Back-to-back frames: the cycle after end of frame is IDLE, so a 0x55 in it starts the next preamble. At least one `control`=0 cycle between frames is required.
- `data` is ignored whenever `control`=0.

## Test plan
- Nominal frame with default parameters:
  - Stimulus: 7×0x55, 0xD5, 01..06, FF FE FD FC FB FA, 08 00, 46 payload bytes, then `control` low.
  - Response: each of the five flags pulses once at its cycle; counter reads 1.
- Bad DST byte:
  - Stimulus: 3rd DST byte is 0x13.
  - Response: no `dst_addr_valid`; state is IDLE; the following frame still validates.
  - Repeat with `promisc`=1: full frame is accepted and counter increments.
- Resync:
  - Stimulus: 0x55 in place of the 2nd SRC byte, followed by 6 more 0x55, then 0xD5.
  - Response: `preamble_valid` pulses.
- Payload bounds:
  - 45 bytes → no `packet_size_valid`.
  - 46 bytes and 1500 bytes → pulse.
  - 1501 bytes → enters DROP; no pulse; counter unchanged.
- Counter saturation:
  - Stimulus: 17 valid frames with CNT_W=4.
  - Response: counter reads 15 after the 15th frame and stays at 15.
- Reset mid-frame:
  - Stimulus: assert `reset` asynchronously during the SRC field.
  - Response: all outputs go 0 immediately, counter is 0, and a fresh frame then validates normally.
